// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Fetch-PC generator for the superscalar front end. Each cycle it presents
//   one aligned fetch group of FETCH_WIDTH instructions with a per-lane valid
//   mask. It walks sequentially through the groups, follows predicted-taken
//   branches from the fetch stage, and takes mispredict redirects from execute.
//   A programmable bubble follows each execute redirect, and the PC holds while
//   decode is stalled.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-high reset
//   stall           decode cannot take the current group; hold the PC
//   redirect_valid  execute-stage redirect request
//   redirect_target redirect PC (low two bits are dropped; nonzero flags misalign_err)
//   pred_taken      predictor reports a taken branch in the current group
//   pred_lane       lane of the predicted-taken branch
//   pred_target     predicted branch target
//   fetch_pc        PC of the first valid instruction in the group
//   fetch_valid     current group is live
//   lane_mask       per-lane valid bits
//   seq_pc          base of the next sequential group
//   squash          one-cycle pulse after a redirect: flush younger front-end state
//   misalign_err    one-cycle pulse: the redirect target was not word aligned

module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter int FETCH_WIDTH = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000,
  parameter int BUBBLE_CYCLES = 1,
  localparam int LW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_target,
  input  logic                   pred_taken,
  input  logic [LW-1:0]          pred_lane,
  input  logic [XLEN-1:0]        pred_target,
  output logic [XLEN-1:0]        fetch_pc,
  output logic                   fetch_valid,
  output logic [FETCH_WIDTH-1:0] lane_mask,
  output logic [XLEN-1:0]        seq_pc,
  output logic                   squash,
  output logic                   misalign_err
);

  localparam int GB = FETCH_WIDTH * 4;
  localparam int OFFW = $clog2(GB);
  localparam logic [XLEN-1:0] GRP_BYTES = XLEN'(GB);
  localparam logic [XLEN-1:0] GRP_MASK = ~(XLEN'(GB - 1));

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_reg, pc_n;
  logic [1:0]      bub_cnt, bub_n;
  logic            squash_n, misalign_n;
  logic [LW-1:0]   start_lane;
  logic            pred_eff;

  // The lane of the first instruction comes from the PC offset inside the
  // group; a single-wide group always starts in lane 0.
  generate
    if (FETCH_WIDTH == 1) begin : g_single
      assign start_lane = '0;
    end else begin : g_multi
      assign start_lane = pc_reg[OFFW-1:2];
    end
  endgenerate

  assign fetch_pc    = pc_reg;
  assign fetch_valid = (state == RUN);
  assign seq_pc      = (pc_reg & GRP_MASK) + GRP_BYTES;

  // A prediction pointing at a lane before the entry point cannot belong to
  // this group, so it is treated as not taken.
  assign pred_eff = fetch_valid & pred_taken & (pred_lane >= start_lane);

  // Lanes from the entry point up to (and including) a predicted-taken
  // branch hold valid instructions.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask[i] = fetch_valid & (LW'(i) >= start_lane) &
                     (!pred_eff | (LW'(i) <= pred_lane));
    end
  end

  // Next-PC selection. An execute redirect beats everything, including
  // stall and an in-progress bubble, which it restarts.
  always_comb begin
    state_n    = state;
    pc_n       = pc_reg;
    bub_n      = bub_cnt;
    squash_n   = 1'b0;
    misalign_n = 1'b0;
    if (redirect_valid) begin
      pc_n       = {redirect_target[XLEN-1:2], 2'b00};
      squash_n   = 1'b1;
      misalign_n = |redirect_target[1:0];
      if (BUBBLE_CYCLES == 0) begin
        state_n = RUN;
        bub_n   = '0;
      end else begin
        state_n = BUBBLE;
        bub_n   = 2'(BUBBLE_CYCLES);
      end
    end else begin
      case (state)
        BOOT: begin
          state_n = RUN;
        end
        BUBBLE: begin
          // The bubble drains even while decode is stalled.
          bub_n = bub_cnt - 2'd1;
          if (bub_cnt <= 2'd1) begin
            state_n = RUN;
            bub_n   = '0;
          end
        end
        RUN: begin
          if (stall) begin
            pc_n = pc_reg;
          end else if (pred_eff) begin
            pc_n = pred_target;
          end else begin
            pc_n = seq_pc;
          end
        end
        default: begin
          state_n = BOOT;
        end
      endcase
    end
  end

  // State, PC and the registered redirect pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_VECTOR;
      state        <= BOOT;
      bub_cnt      <= '0;
      squash       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pc_reg       <= pc_n;
      state        <= state_n;
      bub_cnt      <= bub_n;
      squash       <= squash_n;
      misalign_err <= misalign_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Drives two fetch units (one-cycle and three-cycle redirect bubble) from
//   tables of per-cycle input vectors. Each record lists the inputs held for a
//   cycle and the outputs expected during that same cycle.

module tb_pc_fetch_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        pt;
    logic        pl;
    logic [31:0] ptgt;
    logic [31:0] e_pc;
    logic        e_v;
    logic [1:0]  e_m;
    logic [31:0] e_seq;
    logic        e_sq;
    logic        e_mis;
  } vec_t;

  logic clk;

  logic        a_reset, a_stall, a_rv, a_pt;
  logic [31:0] a_rt, a_ptgt;
  logic [0:0]  a_pl;
  logic [31:0] a_pc, a_seq;
  logic        a_v, a_sq, a_mis;
  logic [1:0]  a_m;

  logic        b_reset, b_stall, b_rv, b_pt;
  logic [31:0] b_rt, b_ptgt;
  logic [0:0]  b_pl;
  logic [31:0] b_pc, b_seq;
  logic        b_v, b_sq, b_mis;
  logic [1:0]  b_m;

  int errors = 0;
  int checks = 0;

  vec_t tab_a[$];
  vec_t tab_b[$];

  pc_fetch_unit #(
    .XLEN(32), .FETCH_WIDTH(2), .RESET_VECTOR(32'h0000_1000), .BUBBLE_CYCLES(1)
  ) u_dut_a (
    .clk(clk), .reset(a_reset), .stall(a_stall),
    .redirect_valid(a_rv), .redirect_target(a_rt),
    .pred_taken(a_pt), .pred_lane(a_pl), .pred_target(a_ptgt),
    .fetch_pc(a_pc), .fetch_valid(a_v), .lane_mask(a_m),
    .seq_pc(a_seq), .squash(a_sq), .misalign_err(a_mis)
  );

  pc_fetch_unit #(
    .XLEN(32), .FETCH_WIDTH(2), .RESET_VECTOR(32'h0000_1000), .BUBBLE_CYCLES(3)
  ) u_dut_b (
    .clk(clk), .reset(b_reset), .stall(b_stall),
    .redirect_valid(b_rv), .redirect_target(b_rt),
    .pred_taken(b_pt), .pred_lane(b_pl), .pred_target(b_ptgt),
    .fetch_pc(b_pc), .fetch_valid(b_v), .lane_mask(b_m),
    .seq_pc(b_seq), .squash(b_sq), .misalign_err(b_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic stall, input logic rv, input logic [31:0] rt,
    input logic pt, input logic pl, input logic [31:0] ptgt,
    input logic [31:0] e_pc, input logic e_v, input logic [1:0] e_m,
    input logic [31:0] e_seq, input logic e_sq, input logic e_mis);
    vec_t r;
    r.rst = rst;  r.stall = stall; r.rv = rv; r.rt = rt;
    r.pt = pt;    r.pl = pl;       r.ptgt = ptgt;
    r.e_pc = e_pc; r.e_v = e_v; r.e_m = e_m; r.e_seq = e_seq;
    r.e_sq = e_sq; r.e_mis = e_mis;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit to_b);
    if (!to_b) begin
      a_reset = v.rst; a_stall = v.stall; a_rv = v.rv; a_rt = v.rt;
      a_pt = v.pt; a_pl = v.pl; a_ptgt = v.ptgt;
    end else begin
      b_reset = v.rst; b_stall = v.stall; b_rv = v.rv; b_rt = v.rt;
      b_pt = v.pt; b_pl = v.pl; b_ptgt = v.ptgt;
    end
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v, input bit from_b);
    if (!from_b) begin
      cmp(tag, "fetch_pc",     a_pc,                v.e_pc);
      cmp(tag, "fetch_valid",  32'(a_v),            32'(v.e_v));
      cmp(tag, "lane_mask",    32'(a_m),            32'(v.e_m));
      cmp(tag, "seq_pc",       a_seq,               v.e_seq);
      cmp(tag, "squash",       32'(a_sq),           32'(v.e_sq));
      cmp(tag, "misalign_err", 32'(a_mis),          32'(v.e_mis));
    end else begin
      cmp(tag, "fetch_pc",     b_pc,                v.e_pc);
      cmp(tag, "fetch_valid",  32'(b_v),            32'(v.e_v));
      cmp(tag, "lane_mask",    32'(b_m),            32'(v.e_m));
      cmp(tag, "seq_pc",       b_seq,               v.e_seq);
      cmp(tag, "squash",       32'(b_sq),           32'(v.e_sq));
      cmp(tag, "misalign_err", 32'(b_mis),          32'(v.e_mis));
    end
  endtask

  initial begin
    // Bubble of one: reset, sequencing, redirect, stall, prediction, wrap,
    // misalignment and back-to-back redirects.
    //              rst st rv target        pt pl ptarget      | pc            v  mask   seq           sq mis
    tab_a.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_1000, 0, 2'b00, 32'h0000_1008, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_1000, 0, 2'b00, 32'h0000_1008, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_1000, 1, 2'b11, 32'h0000_1008, 0, 0));
    tab_a.push_back(mk(0, 0, 1, 32'h2004,     0, 0, 32'h0,       32'h0000_1008, 1, 2'b11, 32'h0000_1010, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2004, 0, 2'b00, 32'h0000_2008, 1, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2004, 1, 2'b10, 32'h0000_2008, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2008, 1, 2'b11, 32'h0000_2010, 0, 0));
    tab_a.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2010, 1, 2'b11, 32'h0000_2018, 0, 0));
    tab_a.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2010, 1, 2'b11, 32'h0000_2018, 0, 0));
    tab_a.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2010, 1, 2'b11, 32'h0000_2018, 0, 0));
    tab_a.push_back(mk(0, 1, 1, 32'h4000,     0, 0, 32'h0,       32'h0000_2010, 1, 2'b11, 32'h0000_2018, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_4000, 0, 2'b00, 32'h0000_4008, 1, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h3000,    32'h0000_4000, 1, 2'b01, 32'h0000_4008, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_3000, 1, 2'b11, 32'h0000_3008, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h5000,    32'h0000_3008, 1, 2'b11, 32'h0000_3010, 0, 0));
    tab_a.push_back(mk(0, 0, 1, 32'h2006,     0, 0, 32'h0,       32'h0000_5000, 1, 2'b11, 32'h0000_5008, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2004, 0, 2'b00, 32'h0000_2008, 1, 1));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h7000,    32'h0000_2004, 1, 2'b10, 32'h0000_2008, 0, 0));
    tab_a.push_back(mk(0, 0, 1, 32'hFFFF_FFF8,0, 0, 32'h0,       32'h0000_2008, 1, 2'b11, 32'h0000_2010, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h9000,    32'hFFFF_FFF8, 0, 2'b00, 32'h0000_0000, 1, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'hFFFF_FFF8, 1, 2'b11, 32'h0000_0000, 0, 0));
    tab_a.push_back(mk(0, 0, 1, 32'h0100,     0, 0, 32'h0,       32'h0000_0000, 1, 2'b11, 32'h0000_0008, 0, 0));
    tab_a.push_back(mk(0, 0, 1, 32'h0203,     0, 0, 32'h0,       32'h0000_0100, 0, 2'b00, 32'h0000_0108, 1, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_0200, 0, 2'b00, 32'h0000_0208, 1, 1));
    tab_a.push_back(mk(0, 1, 0, 32'h0,        1, 1, 32'h6000,    32'h0000_0200, 1, 2'b11, 32'h0000_0208, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_0200, 1, 2'b11, 32'h0000_0208, 0, 0));
    tab_a.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_0208, 1, 2'b11, 32'h0000_0210, 0, 0));

    // Bubble of three: reset in the middle of a bubble, then a second
    // redirect in bubble cycle two restarting the full count.
    tab_b.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_1000, 0, 2'b00, 32'h0000_1008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_1000, 0, 2'b00, 32'h0000_1008, 0, 0));
    tab_b.push_back(mk(0, 0, 1, 32'h2000,     0, 0, 32'h0,       32'h0000_1000, 1, 2'b11, 32'h0000_1008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2000, 0, 2'b00, 32'h0000_2008, 1, 0));
    tab_b.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_2000, 0, 2'b00, 32'h0000_2008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_1000, 0, 2'b00, 32'h0000_1008, 0, 0));
    tab_b.push_back(mk(0, 0, 1, 32'h3000,     0, 0, 32'h0,       32'h0000_1000, 1, 2'b11, 32'h0000_1008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_3000, 0, 2'b00, 32'h0000_3008, 1, 0));
    tab_b.push_back(mk(0, 0, 1, 32'h4004,     0, 0, 32'h0,       32'h0000_3000, 0, 2'b00, 32'h0000_3008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_4004, 0, 2'b00, 32'h0000_4008, 1, 0));
    tab_b.push_back(mk(0, 1, 0, 32'h0,        1, 1, 32'h8000,    32'h0000_4004, 0, 2'b00, 32'h0000_4008, 0, 0));
    tab_b.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,       32'h0000_4004, 0, 2'b00, 32'h0000_4008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_4004, 1, 2'b10, 32'h0000_4008, 0, 0));
    tab_b.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,       32'h0000_4008, 1, 2'b11, 32'h0000_4010, 0, 0));

    a_reset = 1'b1; a_stall = 1'b0; a_rv = 1'b0; a_rt = '0; a_pt = 1'b0; a_pl = '0; a_ptgt = '0;
    b_reset = 1'b1; b_stall = 1'b0; b_rv = 1'b0; b_rt = '0; b_pt = 1'b0; b_pl = '0; b_ptgt = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tab_a.size(); i++) begin
      @(negedge clk);
      applyStimulus(tab_a[i], 1'b0);
      #1;
      checkOutput($sformatf("bub1_row%0d", i), tab_a[i], 1'b0);
    end

    for (int i = 0; i < tab_b.size(); i++) begin
      @(negedge clk);
      applyStimulus(tab_b[i], 1'b1);
      #1;
      checkOutput($sformatf("bub3_row%0d", i), tab_b[i], 1'b1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised fetch-PC generator for the superscalar front end. It produces one aligned fetch group of FETCH_WIDTH instructions per cycle, with a per-lane valid mask. It sequences through the groups and takes branch-prediction redirects from the fetch stage and mispredict redirects from execute. It inserts a programmable redirect bubble, holds the PC on decode back-pressure, and sits between execute/predictor and the I-cache/decode.

Parameters:
XLEN, 32, address width in bits.
FETCH_WIDTH, 2, instructions per fetch group; power of two, range 1..4.
RESET_VECTOR, 32'h0000_1000, PC loaded on reset; must be 4-byte aligned.
BUBBLE_CYCLES, 1, invalid fetch cycles after an execute redirect; range 0..3.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept the current group; hold PC
redirect_valid  input  1  execute-stage mispredict or jump redirect
redirect_target  input  XLEN  redirect PC
pred_taken  input  1  predictor says a taken branch is in the current group
pred_lane  input  $clog2(FETCH_WIDTH) (min 1)  lane of the predicted-taken branch
pred_target  input  XLEN  predicted target
fetch_pc  output  XLEN  PC of the first valid instruction in the group
fetch_valid  output  1  group on fetch_pc/lane_mask is live
lane_mask  output  FETCH_WIDTH  bit i = lane i holds a valid instruction
seq_pc  output  XLEN  next sequential group base: (fetch_pc & ~(G-1)) + G
squash  output  1  one-cycle pulse: flush younger front-end state
misalign_err  output  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
- Definitions:
  - G = FETCH_WIDTH*4 bytes.
  - start_lane = fetch_pc[log2(G)-1:2]; 0 when FETCH_WIDTH=1.
  - All arithmetic is modulo 2^XLEN; seq_pc wraps from the top of memory to 0.
- States:
  - BOOT: fetch_valid=0.
  - RUN: fetch_valid=1.
  - BUBBLE: fetch_valid=0; 2-bit down-counter bub_cnt.
- Reset (synchronous, priority over everything):
  - pc_reg=RESET_VECTOR, state=BOOT, bub_cnt=0.
  - squash=0, misalign_err=0, fetch_valid=0, lane_mask=0.
- BOOT -> RUN unconditionally next cycle, unless redirect_valid is high (see redirect below).
- Next-PC priority, evaluated each clock:
  1. redirect_valid, in any state, overriding stall:
     - pc_reg = redirect_target with bits [1:0] cleared.
     - Next cycle: squash=1; misalign_err=1 if target[1:0]!=0.
     - BUBBLE_CYCLES=0: state=RUN.
     - Otherwise: state=BUBBLE, bub_cnt=BUBBLE_CYCLES.
  2. State BUBBLE:
     - pc_reg holds.
     - bub_cnt decrements regardless of stall; at bub_cnt==1 the next state is RUN.
     - A redirect in BUBBLE reloads the target and restarts the count.
  3. RUN with stall=1: pc_reg and lane_mask hold; fetch_valid stays 1.
  4. RUN with pred_taken=1 and pred_lane >= start_lane: pc_reg = pred_target. No bubble, no squash.
  5. Otherwise: pc_reg = seq_pc.
- lane_mask:
  - Combinational from pc_reg and the registered state.
  - Bit i = fetch_valid & (i >= start_lane) & (!pred_eff | i <= pred_lane).
  - pred_eff = pred_taken & (pred_lane >= start_lane).
  - A pred_lane below start_lane is ignored (treated as not taken).
- pred_* inputs are ignored whenever fetch_valid=0.
- Latency:
  - Redirect to first valid group = 1 + BUBBLE_CYCLES cycles.
  - Predicted redirect = 1 cycle.
- squash and misalign_err are registered single-cycle pulses.
  - Back-to-back redirects give back-to-back pulses.
- fetch_pc = pc_reg.

Test Plan:
1. FETCH_WIDTH=2, BUBBLE_CYCLES=1; deassert reset -> fetch_valid=0 for 1 cycle, pc 0x1000; then 0x1000/mask 11, 0x1008/11, 0x1010/11; seq_pc tracks +8.
2. redirect_valid, target 0x2004, while at 0x1008 -> next cycle pc 0x2004, fetch_valid=0, squash=1; then valid, mask 10; then 0x2008/mask 11.
3. stall held 3 cycles at 0x1010 -> pc and mask unchanged for 3 cycles; redirect to 0x4000 during stall wins -> squash=1, pc 0x4000.
4. pred_taken lane 0 at 0x1010, target 0x3000 -> mask 01, next pc 0x3000. pred_taken lane 0 at 0x2004 -> ignored, mask 10, next 0x2008.
5. Wrap: redirect to 0xFFFF_FFF8 -> group 0xFFFF_FFF8 mask 11, then pc 0x0000_0000. Misaligned redirect 0x2006 -> pc 0x2004, misalign_err and squash pulse together.
6. BUBBLE_CYCLES=3: redirect then reset asserted mid-bubble -> BOOT, pc 0x1000, squash=0. Separately, a second redirect at bubble cycle 2 restarts 3 invalid cycles.
